// File: rtl/control_teclado_if.sv
// Keypad-to-ALU bus: scanner input, key events, operands and the op handshake.
interface control_teclado_if #(
  parameter int unsigned W = 14
) ();
  logic         enable;
  logic [5:0]   indice_boton;
  logic         op_ready;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [1:0]   opcode;
  logic         op_valid;
  logic [1:0]   estado;

  modport master (
    output enable, indice_boton, op_ready,
    input  key_valid, key_code, operand_a, operand_b, opcode, op_valid, estado
  );

  modport slave (
    input  enable, indice_boton, op_ready,
    output key_valid, key_code, operand_a, operand_b, opcode, op_valid, estado
  );
endinterface

// File: rtl/control_teclado.sv
// Keypad debouncer plus operand-entry FSM feeding the calculator ALU.
module control_teclado #(
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned RELEASE_CYC = 16,
  parameter int unsigned NDIG        = 4,
  parameter int unsigned W           = 14
) (
  input logic              clk,
  input logic              reset,
  control_teclado_if.slave bus
);
  localparam int unsigned HIT_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned IDLE_W = $clog2(RELEASE_CYC + 1);
  localparam int unsigned DIG_W  = $clog2(NDIG + 1);

  typedef enum logic {DB_WAIT, DB_LOCKED} db_state_e;
  typedef enum logic [1:0] {
    ENTER_A = 2'b00, ENTER_B = 2'b01, REQ = 2'b10, DONE = 2'b11
  } entry_state_e;

  db_state_e    db_state_q, db_state_d;
  logic [HIT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]   last_code_q, last_code_d;
  logic         key_valid_q, key_valid_d;
  logic [3:0]   key_code_q, key_code_d;
  entry_state_e entry_q, entry_d;
  logic [W-1:0] operand_a_q, operand_a_d;
  logic [W-1:0] operand_b_q, operand_b_d;
  logic [DIG_W-1:0] a_digits_q, a_digits_d;
  logic [DIG_W-1:0] b_digits_q, b_digits_d;
  logic [1:0]   opcode_q, opcode_d;
  logic         op_valid_q, op_valid_d;

  logic [2:0]   col_c, row_c;
  logic         sighting_c;
  logic [3:0]   samp_code_c;
  logic [HIT_W-1:0] hit_inc_c;
  logic         key_evt_c, is_digit_c, is_op_c, is_clr_c, is_eq_c;
  logic [3:0]   digit_val_c;

  // Decode the scanner word and the held key code.
  assign col_c       = bus.indice_boton[5:3];
  assign row_c       = bus.indice_boton[2:0];
  assign sighting_c  = bus.enable && (col_c <= 3'd3) && (row_c <= 3'd3);
  assign samp_code_c = {row_c[1:0], col_c[1:0]};
  assign hit_inc_c   = HIT_W'(hit_cnt_q + 1'b1);

  assign key_evt_c   = key_valid_q && bus.enable;
  assign is_op_c     = (key_code_q[1:0] == 2'd3);
  assign is_clr_c    = (key_code_q == 4'd12);
  assign is_eq_c     = (key_code_q == 4'd14);
  assign is_digit_c  = (key_code_q == 4'd13) ||
                       ((key_code_q[1:0] != 2'd3) && (key_code_q[3:2] != 2'd3));
  // Rows 0-2 hold digits row*3+col+1; code 13 is '0'.
  assign digit_val_c = (key_code_q == 4'd13) ? 4'd0 :
                       4'(({2'b00, key_code_q[3:2]} << 1) + {2'b00, key_code_q[3:2]} +
                          {2'b00, key_code_q[1:0]} + 4'd1);

  function automatic logic [W-1:0] mac10(input logic [W-1:0] x, input logic [3:0] d);
    return W'((x << 3) + (x << 1) + W'(d));
  endfunction

  // Debounce: count matching sightings, emit one event, then wait for release.
  always_comb begin
    db_state_d  = db_state_q;
    hit_cnt_d   = hit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    last_code_d = last_code_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    if (!bus.enable) begin
      db_state_d = DB_WAIT;
      hit_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      case (db_state_q)
        DB_WAIT: begin
          if (sighting_c) begin
            last_code_d = samp_code_c;
            hit_cnt_d   = (samp_code_c == last_code_q) ? hit_inc_c : HIT_W'(1);
            if (hit_cnt_d == HIT_W'(DEBOUNCE)) begin
              key_valid_d = 1'b1;
              key_code_d  = samp_code_c;
              db_state_d  = DB_LOCKED;
              hit_cnt_d   = '0;
              idle_cnt_d  = '0;
            end
          end
        end
        default: begin
          if (sighting_c) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IDLE_W'(RELEASE_CYC - 1)) begin
            db_state_d = DB_WAIT;
            hit_cnt_d  = '0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = IDLE_W'(idle_cnt_q + 1'b1);
          end
        end
      endcase
    end
  end

  // Entry: build operands from key events and run the ALU handshake.
  always_comb begin
    entry_d     = entry_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    a_digits_d  = a_digits_q;
    b_digits_d  = b_digits_q;
    opcode_d    = opcode_q;
    op_valid_d  = op_valid_q;
    if (bus.enable) begin
      if (key_evt_c && is_clr_c && (entry_q != REQ)) begin
        entry_d     = ENTER_A;
        operand_a_d = '0;
        operand_b_d = '0;
        a_digits_d  = '0;
        b_digits_d  = '0;
        opcode_d    = 2'b00;
      end else begin
        case (entry_q)
          ENTER_A: begin
            if (key_evt_c && is_digit_c) begin
              if (a_digits_q < DIG_W'(NDIG)) begin
                operand_a_d = mac10(operand_a_q, digit_val_c);
                a_digits_d  = DIG_W'(a_digits_q + 1'b1);
              end
            end else if (key_evt_c && is_op_c) begin
              opcode_d = key_code_q[3:2];
              entry_d  = ENTER_B;
            end
          end
          ENTER_B: begin
            if (key_evt_c && is_digit_c) begin
              if (b_digits_q < DIG_W'(NDIG)) begin
                operand_b_d = mac10(operand_b_q, digit_val_c);
                b_digits_d  = DIG_W'(b_digits_q + 1'b1);
              end
            end else if (key_evt_c && is_op_c) begin
              if (b_digits_q == '0) opcode_d = key_code_q[3:2];
            end else if (key_evt_c && is_eq_c) begin
              entry_d    = REQ;
              op_valid_d = 1'b1;
            end
          end
          REQ: begin
            if (op_valid_q && bus.op_ready) begin
              op_valid_d = 1'b0;
              entry_d    = DONE;
            end
          end
          default: begin
            if (key_evt_c && is_digit_c) begin
              operand_a_d = W'(digit_val_c);
              a_digits_d  = DIG_W'(1);
              operand_b_d = '0;
              b_digits_d  = '0;
              opcode_d    = 2'b00;
              entry_d     = ENTER_A;
            end
          end
        endcase
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_state_q  <= DB_WAIT;
      hit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      last_code_q <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      entry_q     <= ENTER_A;
      operand_a_q <= '0;
      operand_b_q <= '0;
      a_digits_q  <= '0;
      b_digits_q  <= '0;
      opcode_q    <= '0;
      op_valid_q  <= 1'b0;
    end else begin
      db_state_q  <= db_state_d;
      hit_cnt_q   <= hit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      last_code_q <= last_code_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      entry_q     <= entry_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      a_digits_q  <= a_digits_d;
      b_digits_q  <= b_digits_d;
      opcode_q    <= opcode_d;
      op_valid_q  <= op_valid_d;
    end
  end

  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.operand_a = operand_a_q;
  assign bus.operand_b = operand_b_q;
  assign bus.opcode    = opcode_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.estado    = entry_q;
endmodule

// File: tb/tb_control_teclado.sv
// Directed bench for control_teclado: debounce timing, entry FSM and handshake.
module tb_control_teclado;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  control_teclado_if #(.W(14)) bus ();

  control_teclado #(.DEBOUNCE(4), .RELEASE_CYC(16), .NDIG(4), .W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold a key for 'hold' cycles with a rotating scanner, then release it.
  task automatic press(input logic [3:0] code, input int hold,
                       output int pulses, output int first_i);
    logic [1:0] c;
    logic [1:0] r;
    logic [1:0] slot;
    c = code[1:0];
    r = code[3:2];
    pulses  = 0;
    first_i = -1;
    for (int i = 0; i < hold; i++) begin
      slot = 2'(i % 4);
      bus.indice_boton = (slot == c) ? {1'b0, c, 1'b0, r} : {1'b0, slot, 3'b100};
      tick();
      if (bus.key_valid) begin
        if (pulses == 0) first_i = i;
        pulses++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      bus.indice_boton = 6'b000_100;
      tick();
      if (bus.key_valid) pulses++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.indice_boton = 6'b000_100;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int p, fi;
  int p1, p2;
  logic stable;

  initial begin
    bus.enable       = 1'b1;
    bus.op_ready     = 1'b0;
    bus.indice_boton = 6'b000_100;
    do_reset();
    check("rst_key_valid", 32'(bus.key_valid), 0);
    check("rst_estado",    32'(bus.estado), 0);
    check("rst_operand_a", 32'(bus.operand_a), 0);
    check("rst_op_valid",  32'(bus.op_valid), 0);

    // Held key: one event, fourth sighting plus one cycle
    press(4'd1, 40, p, fi);
    check("t1_pulses", 32'(p), 1);
    check("t1_latency", 32'(fi), 13);
    check("t1_key_code", 32'(bus.key_code), 1);

    // Five digits, fifth ignored
    do_reset();
    press(4'd0, 24, p, fi);
    press(4'd1, 24, p, fi);
    press(4'd2, 24, p, fi);
    press(4'd4, 24, p, fi);
    press(4'd5, 24, p, fi);
    check("t2_operand_a", 32'(bus.operand_a), 1234);
    check("t2_estado", 32'(bus.estado), 0);

    // 7 + - 3 = : minus replaces plus, then handshake
    do_reset();
    press(4'd8, 24, p, fi);
    press(4'd3, 24, p, fi);
    press(4'd7, 24, p, fi);
    press(4'd2, 24, p, fi);
    press(4'd14, 24, p, fi);
    check("t3_opcode", 32'(bus.opcode), 1);
    check("t3_op_valid", 32'(bus.op_valid), 1);
    check("t3_estado_req", 32'(bus.estado), 2);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.op_valid || bus.operand_a != 14'd7 || bus.operand_b != 14'd3) stable = 1'b0;
    end
    check("t3_stable", 32'(stable), 1);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    check("t3_op_valid_drop", 32'(bus.op_valid), 0);
    check("t3_estado_done", 32'(bus.estado), 3);

    // Alternating codes and invalid words never make an event
    do_reset();
    p1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 1) bus.indice_boton = ((i / 4) % 2 == 1) ? 6'b010_001 : 6'b001_001;
      else if (i % 2 == 0) bus.indice_boton = 6'b101_100;
      else bus.indice_boton = 6'b100_000;
      tick();
      if (bus.key_valid) p1++;
    end
    check("t4_alt_pulses", 32'(p1), 0);
    p2 = 0;
    fi = -1;
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       bus.indice_boton = 6'b001_001;
        1:       bus.indice_boton = 6'b101_100;
        2:       bus.indice_boton = 6'b100_000;
        default: bus.indice_boton = 6'b000_101;
      endcase
      tick();
      if (bus.key_valid) begin
        if (p2 == 0) fi = i;
        p2++;
      end
    end
    check("t4_invalid_empty", 32'(fi), 12);
    check("t4_key_code", 32'(bus.key_code), 5);
    bus.indice_boton = 6'b000_100;
    for (int i = 0; i < 20; i++) tick();

    // CLR ignored in REQ; CLR and digit from DONE
    do_reset();
    press(4'd10, 24, p, fi);
    press(4'd11, 24, p, fi);
    press(4'd1, 24, p, fi);
    press(4'd14, 24, p, fi);
    press(4'd12, 24, p, fi);
    check("t5_req_clr_valid", 32'(bus.op_valid), 1);
    check("t5_req_clr_a", 32'(bus.operand_a), 9);
    check("t5_req_opcode", 32'(bus.opcode), 2);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    check("t5_done", 32'(bus.estado), 3);
    press(4'd12, 24, p, fi);
    check("t5_clr_estado", 32'(bus.estado), 0);
    check("t5_clr_a", 32'(bus.operand_a), 0);
    check("t5_clr_b", 32'(bus.operand_b), 0);
    press(4'd4, 24, p, fi);
    press(4'd15, 24, p, fi);
    press(4'd6, 24, p, fi);
    press(4'd14, 24, p, fi);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    press(4'd3, 24, p, fi);
    check("t5_done_op_ignored", 32'(bus.estado), 3);
    press(4'd10, 24, p, fi);
    check("t5_done_digit_a", 32'(bus.operand_a), 9);
    check("t5_done_digit_b", 32'(bus.operand_b), 0);
    check("t5_done_digit_op", 32'(bus.opcode), 0);
    check("t5_done_digit_st", 32'(bus.estado), 0);

    // Reset in REQ with a partial debounce count
    do_reset();
    press(4'd0, 24, p, fi);
    press(4'd3, 24, p, fi);
    press(4'd1, 24, p, fi);
    press(4'd14, 24, p, fi);
    for (int i = 0; i < 11; i++) begin
      bus.indice_boton = (i % 4 == 0) ? 6'b000_001 : 6'b000_100;
      tick();
    end
    check("t6_pre_op_valid", 32'(bus.op_valid), 1);
    reset = 1'b1;
    bus.indice_boton = 6'b000_100;
    tick();
    reset = 1'b0;
    check("t6_op_valid", 32'(bus.op_valid), 0);
    check("t6_estado", 32'(bus.estado), 0);
    check("t6_key_code", 32'(bus.key_code), 0);
    check("t6_operand_a", 32'(bus.operand_a), 0);
    check("t6_operand_b", 32'(bus.operand_b), 0);
    check("t6_opcode", 32'(bus.opcode), 0);
    press(4'd4, 24, p, fi);
    check("t6_full_debounce", 32'(fi), 12);
    check("t6_pulses", 32'(p), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_teclado.md
Name: control_teclado

Overview:
- Sits downstream of the 4x4 keypad scanner and upstream of the calculator ALU.
- Consumes the registered scan index (column in [5:3], row in [2:0]) and debounces it into one-shot key events.
- Runs an operand-entry state machine: operand A, operator, operand B, '='.
- Hands the finished operation to the ALU over a valid/ready handshake.

Parameters:
- DEBOUNCE, 4: consecutive valid sightings of the same key needed to accept a press.
- RELEASE_CYC, 16: consecutive cycles with no valid sighting needed to declare release. Must be at least one full scan period (4 cycles).
- NDIG, 4: maximum decimal digits per operand. Further digits are ignored.
- W, 14: operand width in bits. 10^NDIG-1 must be less than 2^W.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: scan/entry enable.
- indice_boton, in, 6: scanner output. [5:3] is the column 0-3 and [2:0] is the row 0-3. 3'b100 means none; 3'b101 means error.
- op_ready, in, 1: ALU accepts the operation.
- key_valid, out, 1: one-cycle pulse per accepted key press.
- key_code, out, 4: code of the accepted key, held until the next press.
- operand_a, out, W: binary value of operand A.
- operand_b, out, W: binary value of operand B.
- opcode, out, 2: 00 = +, 01 = -, 10 = *, 11 = /.
- op_valid, out, 1: operation request to the ALU.
- estado, out, 2: 00 = ENTER_A, 01 = ENTER_B, 10 = REQ, 11 = DONE.

Behaviour:
- Reset: every output is 0, estado is ENTER_A, and all counters are cleared.

Sample validity and key code:
- A cycle is a valid sighting when enable=1, column field ≤ 3 and row field ≤ 3. Any other cycle is empty.
- code = {row[1:0], col[1:0]}.
- Key map:
  - 0='1', 1='2', 2='3', 3='+'
  - 4='4', 5='5', 6='6', 7='-'
  - 8='7', 9='8', 10='9', 11='*'
  - 12=CLR, 13='0', 14='=', 15='/'

Debounce FSM (states WAIT, LOCKED):
- WAIT:
  - A valid sighting with the same code as the last sighting increments hit_cnt.
  - A valid sighting with a different code sets hit_cnt=1 and records that code.
  - Empty cycles do not change hit_cnt. Scanner columns rotate, so empties between sightings are normal.
  - When hit_cnt reaches DEBOUNCE: in the next cycle key_valid=1, key_code is updated, and the FSM goes to LOCKED.
- LOCKED:
  - idle_cnt counts consecutive empty cycles. Any valid sighting clears it.
  - When idle_cnt reaches RELEASE_CYC: go to WAIT with hit_cnt=0.
  - No key_valid while LOCKED, so a held key produces exactly one event.
- enable=0: hit_cnt and idle_cnt are cleared, the debounce FSM returns to WAIT, and the entry FSM holds.

Entry FSM:
- Acts on key_valid. Registers update on the edge after the key_valid cycle.
- Digit d in ENTER_A: if a_digits < NDIG, operand_a ← operand_a*10+d and a_digits++. Otherwise ignored. The same rule applies to B in ENTER_B.
- Operator key:
  - In ENTER_A: opcode latched, go to ENTER_B (A may be 0 with zero digits).
  - In ENTER_B with b_digits=0: opcode replaced.
  - In ENTER_B with b_digits>0: ignored.
- '=':
  - In ENTER_B: go to REQ and assert op_valid.
  - In ENTER_A: ignored.
- REQ:
  - op_valid, operand_a, operand_b and opcode stay stable until op_ready=1 is seen at an edge.
  - At that edge: op_valid goes to 0 and the FSM goes to DONE.
  - op_ready=1 in the same cycle op_valid first rises completes the transfer in one cycle.
  - All keys, including CLR, are ignored while in REQ.
- DONE:
  - A digit loads operand_a=d, a_digits=1, operand_b=0, b_digits=0, opcode=0, and goes to ENTER_A.
  - An operator or '=' is ignored.
- CLR in ENTER_A, ENTER_B or DONE: operands, opcode and digit counts are cleared, and the FSM goes to ENTER_A.
- Multiply by 10 is implemented as (x<<3)+(x<<1), truncated to W bits. The NDIG bound guarantees no overflow.
- Reset mid-debounce or mid-REQ aborts immediately: op_valid drops in the reset cycle.

Test Plan:
1. Hold col 1 / row 0 (code 1), appearing every 4th cycle, for 40 cycles with DEBOUNCE=4 -> exactly one key_valid, about 13 cycles after the first sighting, key_code=1; no second pulse while held.
2. Press '1','2','3','4','5' (each released ≥RELEASE_CYC) -> operand_a=1234; fifth digit ignored; estado=00.
3. Press '7','+','-','3','=' with op_ready=0 for 5 cycles, then 1 -> opcode=01 (minus replaced plus since B had no digits). op_valid stays high with A=7, B=3 for 5 cycles, falls on the ready edge, and estado=11.
4. Sightings alternating code 5 and code 6 -> no key_valid; indice_boton=6'b101_100 or 6'b100_000 -> treated as empty.
5. In REQ press CLR -> ignored, op_valid stays high. After the handshake, CLR gives estado=00 with operands 0; in DONE, '9' gives operand_a=9, estado=00.
6. Assert reset while op_valid=1 and hit_cnt=3 -> the next cycle has all outputs 0, estado=00, and the next press needs a full DEBOUNCE count.
